// File: rtl/lot_sensor_fsm.sv
// lot_sensor_fsm: debounces two gate beams and tracks the ordered a/b pattern to emit enter/exit strobes and a fault flag.
// Latency: strobe DEBOUNCE+1 edges after the completing raw change (DEBOUNCE+3 when LOT_SENSOR_SYNC_EN is defined).
// Backpressure: none; enter/exit are single-cycle strobes that cannot be stalled.

module lot_sensor_fsm #(
    parameter int DEBOUNCE = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic enter,
    output logic exit,
    output logic fault
);

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);

    typedef enum logic [2:0] {
        IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, FAULT
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] raw;
    logic [1:0] filt;
    logic [3:0] cnt [2];
    logic       enter_nxt, exit_nxt;

`ifdef LOT_SENSOR_SYNC_EN
    logic [1:0] sync_a, sync_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[0], a};
            sync_b <= {sync_b[0], b};
        end
    end

    assign raw = {sync_a[1], sync_b[1]};
`else
    assign raw = {a, b};
`endif

    // filt[1] is the filtered a beam, filt[0] the filtered b beam
    always_ff @(posedge clk) begin
        if (reset) begin
            filt   <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    filt[i] <= raw[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        enter_nxt = 1'b0;
        exit_nxt  = 1'b0;
        case (state)
            IDLE: begin
                case (filt)
                    2'b10:   state_nxt = IN1;
                    2'b01:   state_nxt = OUT1;
                    2'b11:   state_nxt = FAULT;
                    default: state_nxt = IDLE;
                endcase
            end
            IN1: begin
                case (filt)
                    2'b11:   state_nxt = IN2;
                    2'b00:   state_nxt = IDLE;
                    2'b01:   state_nxt = FAULT;
                    default: state_nxt = IN1;
                endcase
            end
            IN2: begin
                case (filt)
                    2'b01:   state_nxt = IN3;
                    2'b10:   state_nxt = IN1;
                    2'b00:   state_nxt = FAULT;
                    default: state_nxt = IN2;
                endcase
            end
            IN3: begin
                case (filt)
                    2'b00: begin
                        state_nxt = IDLE;
                        enter_nxt = 1'b1;
                    end
                    2'b11:   state_nxt = IN2;
                    2'b10:   state_nxt = FAULT;
                    default: state_nxt = IN3;
                endcase
            end
            OUT1: begin
                case (filt)
                    2'b11:   state_nxt = OUT2;
                    2'b00:   state_nxt = IDLE;
                    2'b10:   state_nxt = FAULT;
                    default: state_nxt = OUT1;
                endcase
            end
            OUT2: begin
                case (filt)
                    2'b10:   state_nxt = OUT3;
                    2'b01:   state_nxt = OUT1;
                    2'b00:   state_nxt = FAULT;
                    default: state_nxt = OUT2;
                endcase
            end
            OUT3: begin
                case (filt)
                    2'b00: begin
                        state_nxt = IDLE;
                        exit_nxt  = 1'b1;
                    end
                    2'b11:   state_nxt = OUT2;
                    2'b01:   state_nxt = FAULT;
                    default: state_nxt = OUT3;
                endcase
            end
            FAULT: begin
                if (filt == 2'b00) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // fault is registered from the next state so it tracks the state register exactly
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            enter <= 1'b0;
            exit  <= 1'b0;
            fault <= 1'b0;
        end else begin
            state <= state_nxt;
            enter <= enter_nxt;
            exit  <= exit_nxt;
            fault <= (state_nxt == FAULT);
        end
    end

endmodule
